ready_rx_arbiter: RTL and testbench
===================================

// Module: ready_rx_arbiter
// PURPOSE
//  Destination-domain (clk2) receive controller for NUM_CH ready/data CDC channels.
//  Each source holds data stable while its level 'ready' is high. This block:
//  - synchronizes each ready
//  - arbitrates pending channels round-robin into one registered valid/ready output
//  - returns a per-channel 4-phase level ack to close the handshake.
// PARAMETERS
//  NUM_CH       4  number of source channels (2..16)
//  DATA_WIDTH   8  payload width per channel
//  SYNC_STAGES  2  flops per ready synchronizer (>=2)
// PORTS
//  clk2       in   1                   destination clock; the only clock
//  rstn2      in   1                   reset, asynchronous, active-low
//  ready      in   NUM_CH              async level requests, one bit per channel
//  data       in   NUM_CH*DATA_WIDTH   payloads; ch i = data[i*DATA_WIDTH +: DATA_WIDTH]
//  ack        out  NUM_CH              per-channel level ack back to source domain
//  out_valid  out  1                   output slot holds a word
//  out_ready  in   1                   downstream accepts when out_valid & out_ready
//  out_data   out  DATA_WIDTH          captured payload
//  out_chan   out  $clog2(NUM_CH)      channel index of out_data
//  proto_err  out  1                   sticky: a source dropped ready while PEND
// BEHAVIOUR
//  Reset (async assert, sync release): ack=0, out_valid=0, out_data=0, out_chan=0.
//  Reset also sets: proto_err=0, all sync flops=0, all channels IDLE, rr pointer=0.
//  Mid-operation reset discards the slot and any pending grants.
//  Per-channel FSM (sr = synchronized ready[i]):
//   IDLE: ack=0. sr=1 -> PEND.
//   PEND: requests arbitration. If granted -> ACK.
//         If sr=0 before grant -> IDLE, set proto_err, no output.
//   ACK:  ack=1 (registered). sr=0 -> IDLE (ack drops the same edge).
//  Grant and slot:
//   - slot_free = !out_valid | out_ready.
//   - At most one grant per cycle, only when slot_free. The granted data is
//     captured directly from the data input (stable by protocol).
//   - Grant edge: out_valid<=1, out_data<=data[g], out_chan<=g, ch g -> ACK.
//   - Consume with no grant: out_valid<=0. Consume and grant on the same edge:
//     the slot reloads with no bubble.
//  Round-robin:
//   - Search starts at ptr and wraps NUM_CH-1 -> 0.
//   - On a grant to g, ptr<=(g+1)%NUM_CH. No grant: ptr holds.
//  Latency: ready first sampled high at edge 0 -> PEND after edge SYNC_STAGES ->
//   out_valid and ack high after edge SYNC_STAGES+1 (slot free, no contention).
//  Backpressure: out_valid/out_data/out_chan are held while out_valid & !out_ready.
//   Other channels remain PEND; ack is not raised until that channel is granted.
//  A channel re-requests only after a full IDLE pass (ready low seen via sync).
//   This gives one word per 4-phase cycle.
//  Data is never registered before grant. No path from the async input to an
//   output is combinational.
// STRUCTURE
//  Package ready_rx_pkg:
//   - typedef enum logic [1:0] {IDLE, PEND, ACK} ch_state_t
//   - function rr_pick(req, ptr)
//  Sub-module bit_sync #(SYNC_STAGES): async-reset flop chain, one per channel
//   (generate loop). The top holds the FSM array, arbiter, slot and proto_err.
// TESTING
//  Clock period 1 ns. All ready changes are driven asynchronously to clk2.
//  Latency, NUM_CH=4, SYNC_STAGES=2:
//   ready=4'b0001, data ch0=8'hA5, out_ready=1 -> out_valid 1 cycle, out_data=A5,
//   out_chan=0, ack[0]=1 until 2 cycles after ready[0] drops.
//  Round-robin: ready=4'b1111 held (ch i data=8'h10+i), out_ready=1 ->
//   out_chan sequence 0,1,2,3 on consecutive cycles; each ack rises at its grant.
//  Backpressure: out_ready=0, ready=4'b0110 -> slot holds ch1 (8'h11), ack=0100? no:
//   ack[1]=1 and ack[2]=0. Raise out_ready -> ch2 (8'h12) follows with no bubble.
//  Protocol error: ch3 pending behind a stalled slot drops ready ->
//   ch3 returns to IDLE, proto_err=1 (sticky), no ch3 word emitted.
//  Reset mid-transfer: assert rstn2=0 while out_valid=1 and ack=4'b0011 ->
//   all outputs 0 immediately. After release with ready still high, each
//   channel is re-served once.
//  Random soak: 20 rounds of random ready/data, 10-cycle hold, 5-cycle gap ->
//   every source word appears exactly once, in-order per channel, data matches.

Source files
------------

// File: rtl/ready_rx_arbiter_pkg.sv
// Shared types and the round-robin picker for the ready/data CDC receive arbiter.
`timescale 1ns/1ps
package ready_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } ch_state_t;

    localparam int RR_MAX = 16;

    // Requests above NUM_CH are zero, so wrapping at RR_MAX gives the same order as wrapping at NUM_CH.
    function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req, input logic [3:0] ptr);
        logic [3:0] idx;
        logic [3:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = ptr + 4'(k);
            if (req[idx] && !found) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ready_rx_arbiter_if.sv
// Source-side ready/data/ack channels plus the downstream valid/ready output slot.
`timescale 1ns/1ps
interface ready_rx_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            ready;
    logic [NUM_CH*DATA_WIDTH-1:0] data;
    logic [NUM_CH-1:0]            ack;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CW-1:0]                out_chan;

    modport master (
        output ready, data, out_ready,
        input  ack, out_valid, out_data, out_chan
    );

    modport slave (
        input  ready, data, out_ready,
        output ack, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/ready_rx_arbiter_bit_sync.sv
// Multi-flop synchronizer for one asynchronous level signal.
`timescale 1ns/1ps
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_d;
    logic [STAGES-1:0] sync_q;

    // Shift the async input one stage deeper each clock.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/ready_rx_arbiter.sv
// Receive controller: synchronizes per-channel ready levels, grants one pending
// channel per cycle round-robin into a registered output slot and returns a level ack.
`timescale 1ns/1ps
module ready_rx_arbiter
    import ready_rx_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk2,
    input  logic                 rstn2,
    ready_rx_arbiter_if.slave    bus,
    output logic                 proto_err
);
    localparam int            CW      = $clog2(NUM_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    logic [NUM_CH-1:0]     sr_s;
    logic [NUM_CH-1:0]     req_s;
    logic [NUM_CH-1:0]     drop_s;
    logic [RR_MAX-1:0]     req_ext_s;
    logic [3:0]            ptr_ext_s;
    logic                  slot_free_s;
    logic                  grant_vld_s;
    logic [CW-1:0]         grant_idx_s;

    ch_state_t             state_q [NUM_CH];
    ch_state_t             state_d [NUM_CH];
    logic [NUM_CH-1:0]     ack_q, ack_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]         out_chan_q, out_chan_d;
    logic [CW-1:0]         ptr_q, ptr_d;
    logic                  proto_err_q, proto_err_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk2),
            .rst_n (rstn2),
            .d     (bus.ready[i]),
            .q     (sr_s[i])
        );
    end

    // Pending requests and the single round-robin grant for this cycle.
    always_comb begin
        req_s  = '0;
        drop_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_s[i]  = (state_q[i] == PEND) &&  sr_s[i];
            drop_s[i] = (state_q[i] == PEND) && !sr_s[i];
        end
        req_ext_s               = '0;
        req_ext_s[NUM_CH-1:0]   = req_s;
        ptr_ext_s               = '0;
        ptr_ext_s[CW-1:0]       = ptr_q;
        slot_free_s             = !out_valid_q || bus.out_ready;
        grant_vld_s             = slot_free_s && (|req_s);
        grant_idx_s             = CW'(rr_pick(req_ext_s, ptr_ext_s));
    end

    // Per-channel 4-phase handshake next state.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sr_s[i]) state_d[i] = PEND;
                    else         state_d[i] = IDLE;
                end
                PEND: begin
                    if (!sr_s[i])                                         state_d[i] = IDLE;
                    else if (grant_vld_s && (grant_idx_s == CW'(i)))      state_d[i] = ACK;
                    else                                                  state_d[i] = PEND;
                end
                ACK: begin
                    if (!sr_s[i]) state_d[i] = IDLE;
                    else          state_d[i] = ACK;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Ack, output slot, pointer and sticky error next values.
    always_comb begin
        ack_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ack_d[i] = (state_d[i] == ACK);
        end
        proto_err_d = proto_err_q || (|drop_s);
        if (grant_vld_s) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.data[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
            out_chan_d  = grant_idx_s;
            ptr_d       = (grant_idx_s == LAST_CH) ? '0 : grant_idx_s + CW'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            out_chan_d  = out_chan_q;
            ptr_d       = ptr_q;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            out_chan_d  = out_chan_q;
            ptr_d       = ptr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk2 or negedge rstn2) begin
        if (!rstn2) begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= IDLE;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign proto_err     = proto_err_q;
endmodule

// File: tb/tb_ready_rx_arbiter.sv
// Bench for ready_rx_arbiter: directed cycle table, mid-transfer reset, random 4-phase soak.
`timescale 1ns/1ps
module tb_ready_rx_arbiter;
    localparam int NCH = 4;
    localparam int DW  = 8;

    logic clk2;
    logic rstn2;
    logic proto_err;

    ready_rx_arbiter_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

    ready_rx_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk2      (clk2),
        .rstn2     (rstn2),
        .bus       (bus),
        .proto_err (proto_err)
    );

    typedef struct {
        logic [3:0]  ready;
        logic [31:0] data;
        logic        ordy;
        logic        ev;
        logic [1:0]  ec;
        logic [7:0]  ed;
        logic [3:0]  ack;
        logic        perr;
    } vec_t;

    vec_t       tbl [$];
    logic [7:0] exp_q [NCH][$];
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    bit         rnd_ordy = 1'b0;

    initial begin
        clk2 = 1'b0;
        forever #0.5 clk2 = ~clk2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] rdy, input logic [31:0] d, input logic ordy,
                       input logic ev, input logic [1:0] ec, input logic [7:0] ed,
                       input logic [3:0] ack, input logic perr);
        vec_t v;
        v.ready = rdy; v.data = d; v.ordy = ordy; v.ev = ev;
        v.ec = ec; v.ed = ed; v.ack = ack; v.perr = perr;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk2);
        #0.2;
        if (rnd_ordy) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Scoreboard: every accepted word must be the oldest outstanding word of its channel.
    always @(negedge clk2) begin
        if (mon_en && rstn2 && bus.out_valid && bus.out_ready) begin
            int c;
            logic [7:0] w;
            c = int'(bus.out_chan);
            if (exp_q[c].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got ch%0d data %0h, expected no word", c, bus.out_data);
            end else begin
                w = exp_q[c].pop_front();
                chk($sformatf("word_ch%0d", c), 32'(bus.out_data), 32'(w));
            end
        end
    end

    initial begin
        int n;
        logic [3:0] mask;
        logic [7:0] w;

        rstn2         = 1'b0;
        bus.ready     = '0;
        bus.data      = '0;
        bus.out_ready = 1'b1;

        // Directed cycle table: round-robin, latency, backpressure, protocol error.
        for (int i = 0; i < 4; i++) add(4'b1111, 32'h13121110, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        add(4'b1111, 32'h13121110, 1'b1, 1'b1, 2'd0, 8'h10, 4'b0001, 1'b0);
        add(4'b1111, 32'h13121110, 1'b1, 1'b1, 2'd1, 8'h11, 4'b0011, 1'b0);
        add(4'b1111, 32'h13121110, 1'b1, 1'b1, 2'd2, 8'h12, 4'b0111, 1'b0);
        add(4'b1111, 32'h13121110, 1'b1, 1'b1, 2'd3, 8'h13, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) add(4'b0000, 32'h13121110, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
        add(4'b0000, 32'h13121110, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) add(4'b0001, 32'h000000A5, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        add(4'b0001, 32'h000000A5, 1'b1, 1'b1, 2'd0, 8'hA5, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) add(4'b0000, 32'h000000A5, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);
        add(4'b0000, 32'h000000A5, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) add(4'b0110, 32'h00121100, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        add(4'b0110, 32'h00121100, 1'b0, 1'b1, 2'd1, 8'h11, 4'b0010, 1'b0);
        add(4'b0110, 32'h00121100, 1'b0, 1'b1, 2'd1, 8'h11, 4'b0010, 1'b0);
        add(4'b0110, 32'h00121100, 1'b1, 1'b1, 2'd1, 8'h11, 4'b0010, 1'b0);
        add(4'b0110, 32'h00121100, 1'b1, 1'b1, 2'd2, 8'h12, 4'b0110, 1'b0);
        for (int i = 0; i < 3; i++) add(4'b0000, 32'h00121100, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0110, 1'b0);
        add(4'b0000, 32'h00121100, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) add(4'b0001, 32'h77000020, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) add(4'b1001, 32'h77000020, 1'b0, 1'b1, 2'd0, 8'h20, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) add(4'b0001, 32'h77000020, 1'b0, 1'b1, 2'd0, 8'h20, 4'b0001, 1'b0);
        add(4'b0001, 32'h77000020, 1'b0, 1'b1, 2'd0, 8'h20, 4'b0001, 1'b1);
        add(4'b0001, 32'h77000020, 1'b1, 1'b1, 2'd0, 8'h20, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0000, 32'h77000020, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0001, 1'b1);
        add(4'b0000, 32'h77000020, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);

        repeat (3) @(negedge clk2);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ack",       32'(bus.ack),       32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_chan",  32'(bus.out_chan),  32'd0);
        chk("rst_proto_err", 32'(proto_err),     32'd0);
        @(posedge clk2);
        #0.2 rstn2 = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk2);
            #0.2;
            bus.data      = tbl[i].data;
            bus.ready     = tbl[i].ready;
            bus.out_ready = tbl[i].ordy;
            @(negedge clk2);
            chk($sformatf("row%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d_ack", i),   32'(bus.ack),       32'(tbl[i].ack));
            chk($sformatf("row%0d_perr", i),  32'(proto_err),     32'(tbl[i].perr));
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_chan", i), 32'(bus.out_chan), 32'(tbl[i].ec));
                chk($sformatf("row%0d_data", i), 32'(bus.out_data), 32'(tbl[i].ed));
            end
        end

        // Reset while the slot is full and two channels are acked.
        @(posedge clk2);
        #0.2;
        bus.out_ready = 1'b1;
        bus.data      = 32'h00003231;
        bus.ready     = 4'b0011;
        n = 0;
        do begin
            @(negedge clk2);
            n++;
        end while (bus.ack != 4'b0011 && n < 20);
        chk("mrst_ack_reached", 32'(n < 20), 32'd1);
        chk("mrst_pre_valid", 32'(bus.out_valid), 32'd1);
        #0.1 rstn2 = 1'b0;
        #0.1;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_ack",       32'(bus.ack),       32'd0);
        chk("mrst_out_data",  32'(bus.out_data),  32'd0);
        chk("mrst_out_chan",  32'(bus.out_chan),  32'd0);
        chk("mrst_proto_err", 32'(proto_err),     32'd0);
        exp_q[0].push_back(8'h31);
        exp_q[1].push_back(8'h32);
        mon_en = 1'b1;
        repeat (2) @(posedge clk2);
        #0.2 rstn2 = 1'b1;
        repeat (15) @(posedge clk2);
        #0.2;
        chk("mrst_ch0_served", 32'(exp_q[0].size()), 32'd0);
        chk("mrst_ch1_served", 32'(exp_q[1].size()), 32'd0);
        bus.ready = '0;
        n = 0;
        while (bus.ack != 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        chk("mrst_ack_drop", 32'(n < 20), 32'd1);

        // Random 4-phase soak with random downstream backpressure.
        rnd_ordy = 1'b1;
        for (int r = 0; r < 20; r++) begin
            tick();
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < NCH; c++) begin
                if (mask[c]) begin
                    w = 8'($urandom);
                    bus.data[c*DW +: DW] = w;
                    exp_q[c].push_back(w);
                end
            end
            #(0.1 * real'($urandom_range(1, 4)));
            bus.ready = mask;
            n = 0;
            while (((bus.ack & mask) != mask) && n < 100) begin
                tick();
                n++;
            end
            chk($sformatf("soak%0d_ack_rise", r), 32'(n < 100), 32'd1);
            repeat (10) tick();
            bus.ready = '0;
            n = 0;
            while (bus.ack != 4'b0000 && n < 100) begin
                tick();
                n++;
            end
            chk($sformatf("soak%0d_ack_fall", r), 32'(n < 100), 32'd1);
            repeat (5) tick();
        end
        rnd_ordy = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) tick();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("soak_ch%0d_drained", c), 32'(exp_q[c].size()), 32'd0);
        end
        chk("soak_proto_err", 32'(proto_err), 32'd0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
